fp_post_norm: RTL and testbench
===============================

Name: fp_post_norm

Overview:
- Consumer end of the FPU adder's output interface.
- Takes the registered raw sum (sign, shared exponent, unnormalised two's-complement mantissa) from the add/sub stage.
- Converts it to magnitude, normalises with a leading-zero count and a shift, rounds to nearest-even, handles overflow and underflow, and packs an IEEE-754 word.
- Two-stage valid-qualified pipeline with no backpressure; feeds the FPU result register.

Parameters:
- PRECISION, 32, result format: 32 = single, 64 = double; any other value falls back to single.
- EXPONENT_WIDTH, derived localparam: 8 for 32, 11 for 64.
- MANTISSA_WIDTH, derived localparam: 23 for 32, 52 for 64 (stored fraction bits).

Ports:
- I_Clk  input  1  clock; all logic on the rising edge.
- I_nReset  input  1  reset, synchronous, active-low.
- I_Add_Valid  input  1  sum valid this cycle.
- I_Add_Sign  input  1  MSB of the (MANTISSA_WIDTH+3)-bit two's-complement sum.
- I_Add_Exp  input  EXPONENT_WIDTH  biased exponent shared by both operands.
- I_Add_Mant  input  MANTISSA_WIDTH+2  low bits of the two's-complement sum; bit MANTISSA_WIDTH+1 is the carry position, bit MANTISSA_WIDTH is the hidden-1 position.
- O_Norm_Valid  output  1  packed result valid.
- O_Norm_Result  output  PRECISION  {sign, exponent, fraction}.

Behaviour:
- Reset: a synchronous active-low reset clears every pipeline register; O_Norm_Valid=0 and O_Norm_Result=0 on the first edge with I_nReset=0. In-flight data is discarded.
- Latency: exactly 2 cycles from I_Add_Valid to O_Norm_Valid. Throughput is 1 per cycle; back-to-back inputs are independent.
- The valid pipeline always shifts. Data registers load only when their stage valid is 1, and otherwise hold.
- Stage 1:
  - S = {I_Add_Sign, I_Add_Mant}.
  - Sign = S MSB.
  - Mag = abs(S), truncated to MANTISSA_WIDTH+2 bits. Mag fits in that width by construction.
  - Register Mag, Exp and Sign.
  - Compute LZ = leading-zero count of Mag[MANTISSA_WIDTH:0]; the range is 0..MANTISSA_WIDTH+1.
- Stage 2, in priority order:
  - Mag==0: the result is +0 (all zeros) regardless of sign.
  - Mag[MANTISSA_WIDTH+1]==1 (carry): shift right by 1 and set Exp+1. Guard = dropped bit, sticky = 0.
  - Otherwise shift left by LZ and set Exp-LZ. There is no guard bit, so the result is exact.
  - Round-to-nearest-even: increment the fraction iff guard=1 and the kept LSB=1. A rounding carry-out renormalises: fraction becomes 0 and the exponent increments.
  - Underflow: if the computed exponent (in signed arithmetic) is <= 0, or I_Add_Exp==0 with Mag!=0, the result is a signed zero {Sign, 0...}. Denormals are not produced.
  - Overflow: if the final exponent is >= all-ones, the result is signed infinity {Sign, all-ones, 0}.
  - Otherwise the result is {Sign, final exponent, fraction[MANTISSA_WIDTH-1:0]}.
- Exponent arithmetic is carried in EXPONENT_WIDTH+2 bits signed, so wrap-around is impossible.
- Inputs while I_Add_Valid=0 are don't-care. When O_Norm_Valid=0, O_Norm_Result holds its last value.

Optional Feature:
- Macro: FP_POST_NORM_FLAGS_EN.
- Defined: adds port O_Norm_Flags, output, 4 bits, registered with O_Norm_Result, cleared on reset.
  - bit3 = overflow (infinity produced).
  - bit2 = underflow (flushed to zero, Mag!=0).
  - bit1 = inexact (guard=1, or underflow/overflow).
  - bit0 = zero result.
- Undefined: the port and all flag logic are absent, and the result datapath is identical.

Test Plan:
- 1.0+1.0: Exp=127, Mant=0x1000000, Sign=0 -> two cycles later Valid=1, Result=0x40000000.
- Negative: Sign=1, Mant=0x1800000, Exp=127 -> 0xBF800000. Full cancellation: Sign=0, Mant=0, Exp=127 -> 0x00000000 (flags 0001).
- Left normalise: Mant=0x0400000, Exp=127 -> 0x3F000000.
- Rounding:
  - Mant=0x1000001, Exp=127 (tie, even) -> 0x40000000 (inexact set).
  - Mant=0x1000003 -> 0x40000002.
  - Mant=0x1FFFFFF, Exp=127 -> round carry -> 0x40800000.
- Limits:
  - Exp=254, Mant=0x1000000 -> 0x7F800000 (flags 1010).
  - Exp=1, Mant=0x0400000 -> 0x00000000 (flags 0110).
- Pipeline: 4 back-to-back valids followed by 1 idle cycle -> 4 consecutive correct results in order. Asserting I_Nreset low mid-stream -> Valid=0 and Result=0 on the next edge, with no stale output after release.

Source files
------------

// File: rtl/fp_post_norm.sv
// fp_post_norm: post-normalisation and packing stage at the output of the FPU adder.
// It takes the registered raw two's-complement sum and turns it into an IEEE-754 word.
//
// Stage 1 forms the magnitude and counts its leading zeros.
// Stage 2 normalises, rounds to nearest-even, resolves overflow/underflow and packs the word.
//
// Optional build macro FP_POST_NORM_FLAGS_EN adds the O_Norm_Flags output.
// Its bit layout is {overflow, underflow, inexact, zero}.
module fp_post_norm #(
  parameter int PRECISION = 32
) (
  input  logic                                      I_Clk,
  input  logic                                      I_nReset,
  input  logic                                      I_Add_Valid,
  input  logic                                      I_Add_Sign,
  input  logic [((PRECISION == 64) ? 11 : 8)-1:0]   I_Add_Exp,
  input  logic [((PRECISION == 64) ? 52 : 23)+1:0]  I_Add_Mant,
  output logic                                      O_Norm_Valid,
  output logic [((PRECISION == 64) ? 64 : 32)-1:0]  O_Norm_Result
`ifdef FP_POST_NORM_FLAGS_EN
  ,
  output logic [3:0]                                O_Norm_Flags
`endif
);

  localparam int RW             = (PRECISION == 64) ? 64 : 32;
  localparam int EXPONENT_WIDTH = (PRECISION == 64) ? 11 : 8;
  localparam int MANTISSA_WIDTH = (PRECISION == 64) ? 52 : 23;
  localparam int EW             = EXPONENT_WIDTH;
  localparam int MW             = MANTISSA_WIDTH;
  localparam int LZW            = $clog2(MW + 2);
  localparam int XW             = EW + 2;

  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic signed [XW-1:0] EXP_MAX  = {2'b00, {EW{1'b1}}};

  // Stage 1 registers
  logic           valid1_q, valid1_d;
  logic [MW+1:0]  mag_q, mag_d;
  logic [EW-1:0]  exp_q, exp_d;
  logic           sign_q, sign_d;
  logic [LZW-1:0] lz_q, lz_d;

  // Stage 2 registers
  logic           valid2_q, valid2_d;
  logic [RW-1:0]  result_q, result_d;
`ifdef FP_POST_NORM_FLAGS_EN
  logic [3:0]     flags_q, flags_d;
`endif

  // Stage 1 working values
  logic [MW+1:0]  mag_new;
  logic [LZW-1:0] lz_new;

  // Stage 2 working values
  logic [MW-1:0]         kept_frac;
  logic                  guard;
  logic                  round_up;
  logic [MW:0]           frac_sum;
  logic [MW-1:0]         frac_final;
  logic signed [XW-1:0]  exp_base;
  logic signed [XW-1:0]  lz_ext;
  logic signed [XW-1:0]  exp_norm;
  logic signed [XW-1:0]  exp_final;
  logic                  mag_zero;
  logic                  underflow;
  logic                  overflow;
  logic [RW-1:0]         res_new;

  // Stage 1: magnitude of the sum and the leading-zero count below the carry position.
  // Negating only the low bits is enough, since the magnitude always fits there.
  always_comb begin
    mag_new = I_Add_Sign ? (~I_Add_Mant + (MW+2)'(1)) : I_Add_Mant;
    lz_new  = LZW'(MW + 1);
    for (int i = 0; i <= MW; i++) begin
      if (mag_new[i]) begin
        lz_new = LZW'(MW - i);
      end
    end
    valid1_d = I_Add_Valid;
    mag_d    = I_Add_Valid ? mag_new    : mag_q;
    exp_d    = I_Add_Valid ? I_Add_Exp  : exp_q;
    sign_d   = I_Add_Valid ? I_Add_Sign : sign_q;
    lz_d     = I_Add_Valid ? lz_new     : lz_q;
  end

  // Stage 2: normalise, round to nearest-even, then resolve zero/underflow/overflow into a packed word.
  always_comb begin
    exp_base = {2'b00, exp_q};
    lz_ext   = XW'(lz_q);
    if (mag_q[MW+1]) begin
      kept_frac = mag_q[MW:1];
      guard     = mag_q[0];
      exp_norm  = exp_base + EXP_ONE;
    end else begin
      kept_frac = MW'(mag_q[MW:0] << lz_q);
      guard     = 1'b0;
      exp_norm  = exp_base - lz_ext;
    end
    round_up   = guard & kept_frac[0];
    frac_sum   = {1'b0, kept_frac} + {{MW{1'b0}}, round_up};
    frac_final = frac_sum[MW-1:0];
    exp_final  = frac_sum[MW] ? (exp_norm + EXP_ONE) : exp_norm;

    mag_zero  = (mag_q == '0);
    underflow = !mag_zero && ((exp_final <= EXP_ZERO) || (exp_q == '0));
    overflow  = !mag_zero && !underflow && (exp_final >= EXP_MAX);

    if (mag_zero) begin
      res_new = '0;
    end else if (underflow) begin
      res_new = {sign_q, {(RW-1){1'b0}}};
    end else if (overflow) begin
      res_new = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
    end else begin
      res_new = {sign_q, exp_final[EW-1:0], frac_final};
    end

    valid2_d = valid1_q;
    result_d = valid1_q ? res_new : result_q;
`ifdef FP_POST_NORM_FLAGS_EN
    flags_d  = valid1_q ? {overflow, underflow, (guard | underflow | overflow), mag_zero} : flags_q;
`endif
  end

  // Pipeline registers: valids always advance, data only loads behind a valid, and reset clears everything.
  always_ff @(posedge I_Clk) begin
    if (!I_nReset) begin
      valid1_q <= 1'b0;
      mag_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      lz_q     <= '0;
      valid2_q <= 1'b0;
      result_q <= '0;
`ifdef FP_POST_NORM_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      valid1_q <= valid1_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      lz_q     <= lz_d;
      valid2_q <= valid2_d;
      result_q <= result_d;
`ifdef FP_POST_NORM_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  assign O_Norm_Valid  = valid2_q;
  assign O_Norm_Result = result_q;
`ifdef FP_POST_NORM_FLAGS_EN
  assign O_Norm_Flags  = flags_q;
`endif

endmodule

// File: tb/tb_fp_post_norm.sv
// tb_fp_post_norm: directed test of fp_post_norm in single precision.
// Expected words are hand-computed IEEE-754 values.
module tb_fp_post_norm;

  logic        I_Clk = 1'b0;
  logic        I_nReset;
  logic        I_Add_Valid;
  logic        I_Add_Sign;
  logic [7:0]  I_Add_Exp;
  logic [24:0] I_Add_Mant;
  logic        O_Norm_Valid;
  logic [31:0] O_Norm_Result;
`ifdef FP_POST_NORM_FLAGS_EN
  logic [3:0]  O_Norm_Flags;
`endif

  int assertCount = 0;
  int failCount   = 0;
  logic [31:0] lastRes   = '0;
  logic [3:0]  lastFlags = '0;

  fp_post_norm #(.PRECISION(32)) dut (
    .I_Clk        (I_Clk),
    .I_nReset     (I_nReset),
    .I_Add_Valid  (I_Add_Valid),
    .I_Add_Sign   (I_Add_Sign),
    .I_Add_Exp    (I_Add_Exp),
    .I_Add_Mant   (I_Add_Mant),
    .O_Norm_Valid (O_Norm_Valid),
    .O_Norm_Result(O_Norm_Result)
`ifdef FP_POST_NORM_FLAGS_EN
    ,
    .O_Norm_Flags (O_Norm_Flags)
`endif
  );

  // Free-running clock with a 10 ns period.
  always #5 I_Clk = ~I_Clk;

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic s, input logic [7:0] e, input logic [24:0] m);
    I_Add_Valid = v;
    I_Add_Sign  = s;
    I_Add_Exp   = e;
    I_Add_Mant  = m;
  endtask

  task automatic checkOutput(input string tag, input logic expValid, input logic [31:0] expRes,
                             input logic [3:0] expFlags);
    assertCount++;
    assert (O_Norm_Valid === expValid) else begin
      failCount++;
      $error("[TB] FAIL %s valid: got %b, expected %b", tag, O_Norm_Valid, expValid);
    end
    assertCount++;
    assert (O_Norm_Result === expRes) else begin
      failCount++;
      $error("[TB] FAIL %s result: got %h, expected %h (flags %b)", tag, O_Norm_Result, expRes, expFlags);
    end
`ifdef FP_POST_NORM_FLAGS_EN
    assertCount++;
    assert (O_Norm_Flags === expFlags) else begin
      failCount++;
      $error("[TB] FAIL %s flags: got %b, expected %b", tag, O_Norm_Flags, expFlags);
    end
`endif
  endtask

  // One isolated transaction: no output after 1 cycle, result after 2, held afterwards.
  task automatic runSingle(input string tag, input logic s, input logic [7:0] e, input logic [24:0] m,
                           input logic [31:0] expRes, input logic [3:0] expFlags);
    @(negedge I_Clk);
    applyStimulus(1'b1, s, e, m);
    @(negedge I_Clk);
    checkOutput({tag, " lat1"}, 1'b0, lastRes, lastFlags);
    applyStimulus(1'b0, 1'b0, 8'h00, 25'h0);
    @(negedge I_Clk);
    checkOutput({tag, " out"}, 1'b1, expRes, expFlags);
    @(negedge I_Clk);
    checkOutput({tag, " hold"}, 1'b0, expRes, expFlags);
    lastRes   = expRes;
    lastFlags = expFlags;
  endtask

  logic        pSign [4];
  logic [7:0]  pExp  [4];
  logic [24:0] pMant [4];
  logic [31:0] pRes  [4];
  logic [3:0]  pFlg  [4];

  initial begin
    // Reset state
    I_nReset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 25'h0);
    repeat (2) @(negedge I_Clk);
    checkOutput("reset", 1'b0, 32'h0, 4'b0000);
    I_nReset = 1'b1;

    // Main function and boundaries
    runSingle("one_plus_one",  1'b0, 8'd127, 25'h1000000, 32'h40000000, 4'b0000);
    runSingle("negative",      1'b1, 8'd127, 25'h1800000, 32'hBF800000, 4'b0000);
    runSingle("cancel",        1'b0, 8'd127, 25'h0000000, 32'h00000000, 4'b0001);
    runSingle("neg_cancel",    1'b1, 8'd127, 25'h0000000, 32'h00000000, 4'b0001);
    runSingle("left_norm",     1'b0, 8'd127, 25'h0400000, 32'h3F000000, 4'b0000);
    runSingle("lz_max",        1'b0, 8'd127, 25'h0000001, 32'h34000000, 4'b0000);
    runSingle("tie_even",      1'b0, 8'd127, 25'h1000001, 32'h40000000, 4'b0010);
    runSingle("tie_odd",       1'b0, 8'd127, 25'h1000003, 32'h40000002, 4'b0010);
    runSingle("round_carry",   1'b0, 8'd127, 25'h1FFFFFF, 32'h40800000, 4'b0010);
    runSingle("max_normal",    1'b0, 8'd254, 25'h0800000, 32'h7F000000, 4'b0000);
    runSingle("overflow",      1'b0, 8'd254, 25'h1000000, 32'h7F800000, 4'b1010);
    runSingle("neg_overflow",  1'b1, 8'd254, 25'h1000000, 32'hFF800000, 4'b1010);
    runSingle("round_ovf",     1'b0, 8'd253, 25'h1FFFFFF, 32'h7F800000, 4'b1010);
    runSingle("underflow",     1'b0, 8'd1,   25'h0400000, 32'h00000000, 4'b0110);
    runSingle("neg_underflow", 1'b1, 8'd1,   25'h1C00000, 32'h80000000, 4'b0110);
    runSingle("exp_zero",      1'b0, 8'd0,   25'h1000000, 32'h00000000, 4'b0110);

    // Back-to-back pipeline: four valids then one idle cycle
    pSign[0] = 1'b0; pExp[0] = 8'd127; pMant[0] = 25'h1000000; pRes[0] = 32'h40000000; pFlg[0] = 4'b0000;
    pSign[1] = 1'b1; pExp[1] = 8'd127; pMant[1] = 25'h1800000; pRes[1] = 32'hBF800000; pFlg[1] = 4'b0000;
    pSign[2] = 1'b0; pExp[2] = 8'd127; pMant[2] = 25'h1000003; pRes[2] = 32'h40000002; pFlg[2] = 4'b0010;
    pSign[3] = 1'b1; pExp[3] = 8'd127; pMant[3] = 25'h1C00000; pRes[3] = 32'hBF000000; pFlg[3] = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      @(negedge I_Clk);
      if (c >= 2) checkOutput($sformatf("pipe%0d", c - 2), 1'b1, pRes[c-2], pFlg[c-2]);
      if (c < 4) applyStimulus(1'b1, pSign[c], pExp[c], pMant[c]);
      else       applyStimulus(1'b0, 1'b0, 8'h00, 25'h0);
    end
    @(negedge I_Clk);
    checkOutput("pipe_idle", 1'b0, pRes[3], pFlg[3]);

    // Reset asserted mid-stream
    applyStimulus(1'b1, 1'b0, 8'd127, 25'h1000000);
    @(negedge I_Clk);
    applyStimulus(1'b1, 1'b1, 8'd127, 25'h1800000);
    @(negedge I_Clk);
    checkOutput("mid_pre", 1'b1, 32'h40000000, 4'b0000);
    applyStimulus(1'b1, 1'b0, 8'd127, 25'h0400000);
    I_nReset = 1'b0;
    @(negedge I_Clk);
    checkOutput("mid_reset", 1'b0, 32'h0, 4'b0000);
    I_nReset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 25'h0);
    @(negedge I_Clk);
    checkOutput("post_reset1", 1'b0, 32'h0, 4'b0000);
    @(negedge I_Clk);
    checkOutput("post_reset2", 1'b0, 32'h0, 4'b0000);
    lastRes   = '0;
    lastFlags = '0;
    runSingle("recover",       1'b0, 8'd127, 25'h1000003, 32'h40000002, 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
